// File: rtl/hilo_muldiv.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply (IDLE->FIX).
module hilo_muldiv #(
  parameter int unsigned ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
  localparam logic [4:0] CntLast = 5'(ITER_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        accept, sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next;
  logic [32:0] div_r;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFix) && !flush;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign accept   = in_valid && in_ready && !flush;

  assign sgn   = (op == OpMult) || (op == OpDiv);
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  // Shift-add: low half holds the remaining multiplier bits, high half the partial product.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide: high half is the partial remainder, low half shifts in quotient bits.
  assign div_r    = {acc_q[63:32], acc_q[31]};
  assign div_ge   = div_r >= {1'b0, opb_q};
  assign div_sub  = div_r[31:0] - opb_q;
  assign div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1} : {div_r[31:0], acc_q[30:0], 1'b0};

  assign prod = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quo  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpMthi: hi_d = a;
            OpMtlo: lo_d = a;
            OpMult, OpMultu: begin
              is_div_d = 1'b0;
              neg_d    = a_neg ^ b_neg;
              dz_d     = 1'b0;
              cnt_d    = 5'd0;
`ifdef MULDIV_FAST_MUL_EN
              acc_d    = fast_prod;
              state_d  = StFix;
`else
              acc_d    = {32'd0, b_mag};
              opb_d    = a_mag;
              state_d  = StRun;
`endif
            end
            OpDiv, OpDivu: begin
              is_div_d = 1'b1;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              dz_d     = (b == 32'd0);
              a_d      = a;
              acc_d    = {32'd0, a_mag};
              opb_d    = b_mag;
              cnt_d    = 5'd0;
              state_d  = StRun;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == CntLast) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          if (!is_div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (dz_q) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      a_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

endmodule
